iir_ch_scheduler: RTL and testbench

Time-multiplexed scheduler that shares one first-order IIR section (y = b0·x + ((−a1·ry) >>> G_SAIDA_LOG)) between NCH input channels. It owns the per-channel feedback state ry, arbitrates channel requests round-robin, and sequences the shared multiply datapath. It also holds the runtime-configurable b0/a1 coefficients. It sits between the channel sample sources and the downstream filter-output consumers, and replaces one IIR instance per channel.

---
 rtl/iir_sched_pkg.sv | 41 ++++
 rtl/iir_ch_scheduler_if.sv | 44 ++++
 rtl/iir_ch_scheduler_step.sv | 45 ++++
 rtl/iir_ch_scheduler.sv | 152 +++++++++++++++
 tb/tb_iir_ch_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iir_sched_pkg.sv
// rtl/iir_sched_pkg.sv - shared types, defaults and width helpers for the IIR channel scheduler
//
// Purpose: state encoding, coefficient width default and the width functions
// used by the interface, the scheduler and the shared arithmetic step.
// Ports: none (package).

package iir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CALC  = 2'd2,
    EMIT  = 2'd3
  } state_t;

  localparam int COEF_W_DEF = 16;

  // Ceiling log2, never below 1 so a channel index always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Width of the filter output y.
  function automatic int out_w(input int bits_in);
    return bits_in + 17;
  endfunction

  // Width at which the feedback product is evaluated before the shift.
  function automatic int fb_w(input int bits_in, input int g_log);
    return bits_in + g_log + 17;
  endfunction

endpackage

// File: rtl/iir_ch_scheduler_if.sv
// rtl/iir_ch_scheduler_if.sv - sample, coefficient and result bundle of the IIR channel scheduler
//
// Purpose: groups the per-channel request/accept handshake, coefficient
// writes, state clear and the result strobe.
// Signals:
//   in_valid[NCH]        per-channel sample request (master)
//   in_data[NCH*BITS_IN] flattened samples, channel k at [k*BITS_IN +: BITS_IN] (master)
//   in_ready[NCH]        one-hot accept pulse (slave)
//   cfg_we, cfg_b0, cfg_a1  coefficient write (master)
//   clear_state          zero all channel feedback state (master)
//   out_valid, out_ch, out_data  one-cycle result strobe (slave)

interface iir_ch_scheduler_if
  import iir_sched_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int BITS_IN = 33,
  parameter int COEF_W  = COEF_W_DEF
);
  localparam int CW = clog2(NCH);
  localparam int OW = out_w(BITS_IN);

  logic [NCH-1:0]         in_valid;
  logic [NCH*BITS_IN-1:0] in_data;
  logic [NCH-1:0]         in_ready;
  logic                   cfg_we;
  logic signed [COEF_W-1:0] cfg_b0;
  logic signed [COEF_W-1:0] cfg_a1;
  logic                   clear_state;
  logic                   out_valid;
  logic [CW-1:0]          out_ch;
  logic signed [OW-1:0]   out_data;

  modport master (
    output in_valid, in_data, cfg_we, cfg_b0, cfg_a1, clear_state,
    input  in_ready, out_valid, out_ch, out_data
  );

  modport slave (
    input  in_valid, in_data, cfg_we, cfg_b0, cfg_a1, clear_state,
    output in_ready, out_valid, out_ch, out_data
  );

endinterface

// File: rtl/iir_ch_scheduler_step.sv
// rtl/iir_ch_scheduler_step.sv - combinational first-order IIR step shared by all channels
//
// Purpose: y = b0*x + ((-a1*ry) >>> G_SAIDA_LOG), two's-complement wrap.
// Ports:
//   x   in  BITS_IN  signed sample
//   ry  in  OW       signed feedback state of the channel
//   b0  in  COEF_W   signed feed-forward coefficient
//   a1  in  COEF_W   signed feedback coefficient
//   y   out OW       signed result

module iir_step
  import iir_sched_pkg::*;
#(
  parameter int BITS_IN     = 33,
  parameter int G_SAIDA_LOG = 10,
  parameter int COEF_W      = COEF_W_DEF,
  localparam int OW         = out_w(BITS_IN),
  localparam int PW         = fb_w(BITS_IN, G_SAIDA_LOG)
) (
  input  logic signed [BITS_IN-1:0] x,
  input  logic signed [OW-1:0]      ry,
  input  logic signed [COEF_W-1:0]  b0,
  input  logic signed [COEF_W-1:0]  a1,
  output logic signed [OW-1:0]      y
);

  logic signed [OW-1:0] x_e;
  logic signed [OW-1:0] b0_e;
  logic signed [OW-1:0] yz;
  logic signed [PW-1:0] a1_e;
  logic signed [PW-1:0] ry_e;
  logic signed [PW-1:0] yp;

  // Operands are sign-extended to the evaluation width first so the products
  // wrap at exactly that width.
  assign x_e  = {{(OW - BITS_IN){x[BITS_IN-1]}}, x};
  assign b0_e = {{(OW - COEF_W){b0[COEF_W-1]}}, b0};
  assign a1_e = {{(PW - COEF_W){a1[COEF_W-1]}}, a1};
  assign ry_e = {{(PW - OW){ry[OW-1]}}, ry};

  assign yz = x_e * b0_e;
  assign yp = (-a1_e) * ry_e;
  assign y  = yz + OW'(yp >>> G_SAIDA_LOG);

endmodule

// File: rtl/iir_ch_scheduler.sv
// rtl/iir_ch_scheduler.sv - round-robin scheduler sharing one IIR step between NCH channels
//
// Purpose: arbitrates channel requests, holds per-channel feedback state ry
// and the live b0/a1 coefficients, and sequences IDLE->FETCH->CALC->EMIT
// (one sample per four cycles, result three cycles after accept).
// Ports:
//   clock    in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   bus      slave modport of iir_ch_scheduler_if (requests, config, results)

module iir_ch_scheduler
  import iir_sched_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int BITS_IN     = 33,
  parameter int G_SAIDA_LOG = 10,
  parameter int COEF_W      = COEF_W_DEF,
  parameter int B0_RST      = 785,
  parameter int A1_RST      = -1366
) (
  input  logic              clock,
  input  logic              reset_n,
  iir_ch_scheduler_if.slave bus
);

  localparam int CW = clog2(NCH);
  localparam int OW = out_w(BITS_IN);

  state_t state, state_nxt;

  logic [CW-1:0]             last_grant;
  logic [CW-1:0]             ch;
  logic [CW-1:0]             grant;
  logic                      found;
  logic [BITS_IN-1:0]        x_sel;
  logic [NCH-1:0]            in_ready_c;

  logic signed [BITS_IN-1:0] x_r;
  logic signed [COEF_W-1:0]  b0, a1;
  logic signed [COEF_W-1:0]  b0_s, a1_s;
  logic signed [OW-1:0]      ry [NCH];
  logic signed [OW-1:0]      ry_r;
  logic signed [OW-1:0]      y_r;
  logic signed [OW-1:0]      y_c;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int            idx_i;
    logic [CW-1:0] idx;
    found = 1'b0;
    grant = '0;
    idx_i = 0;
    idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx_i = int'(last_grant) + i;
      if (idx_i >= NCH) idx_i = idx_i - NCH;
      idx = CW'(idx_i);
      if (!found && bus.in_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    x_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant == CW'(k)) x_sel = bus.in_data[k*BITS_IN +: BITS_IN];
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready_c = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt  = FETCH;
          in_ready_c = NCH'(1) << grant;
        end
      end
      FETCH:   state_nxt = CALC;
      CALC:    state_nxt = EMIT;
      EMIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The accept pulse is combinational from the requests, so it is forced low
  // while reset is held even if a source keeps requesting.
  assign bus.in_ready  = reset_n ? in_ready_c : '0;
  assign bus.out_valid = (state == EMIT);
  assign bus.out_ch    = ch;
  assign bus.out_data  = y_r;

  iir_step #(
    .BITS_IN     (BITS_IN),
    .G_SAIDA_LOG (G_SAIDA_LOG),
    .COEF_W      (COEF_W)
  ) u_step (
    .x  (x_r),
    .ry (ry_r),
    .b0 (b0_s),
    .a1 (a1_s),
    .y  (y_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= CW'(NCH - 1);
      ch         <= '0;
      x_r        <= '0;
      b0         <= COEF_W'(B0_RST);
      a1         <= COEF_W'(A1_RST);
      b0_s       <= '0;
      a1_s       <= '0;
      ry_r       <= '0;
      y_r        <= '0;
      for (int k = 0; k < NCH; k++) ry[k] <= '0;
    end else begin
      state <= state_nxt;

      if (bus.cfg_we) begin
        b0 <= bus.cfg_b0;
        a1 <= bus.cfg_a1;
      end

      case (state)
        IDLE: begin
          if (found) begin
            ch   <= grant;
            x_r  <= x_sel;
            // Shadow copy: a coefficient write during the sample does not
            // affect it.
            b0_s <= b0;
            a1_s <= a1;
          end
        end
        FETCH:   ry_r <= ry[ch];
        CALC:    y_r  <= y_c;
        EMIT:    last_grant <= ch;
        default: ;
      endcase

      // Clear beats the EMIT write-back; the result is still emitted.
      if (bus.clear_state) begin
        for (int k = 0; k < NCH; k++) ry[k] <= '0;
      end else if (state == EMIT) begin
        ry[ch] <= y_r;
      end
    end
  end

endmodule

// File: tb/tb_iir_ch_scheduler.sv
// tb/tb_iir_ch_scheduler.sv - self-checking bench for iir_ch_scheduler

module tb_iir_ch_scheduler;
  import iir_sched_pkg::*;

  localparam int NCH     = 4;
  localparam int BITS_IN = 33;
  localparam int G       = 10;
  localparam int COEF_W  = 16;
  localparam int OW      = BITS_IN + 17;
  localparam int PW      = BITS_IN + G + 17;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  iir_ch_scheduler_if #(.NCH(NCH), .BITS_IN(BITS_IN), .COEF_W(COEF_W)) bus ();

  iir_ch_scheduler #(
    .NCH(NCH), .BITS_IN(BITS_IN), .G_SAIDA_LOG(G), .COEF_W(COEF_W),
    .B0_RST(785), .A1_RST(-1366)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  function automatic longint model_y(input longint b0, input longint a1,
                                     input longint x, input longint ry);
    longint yz, yp;
    yz = wrapw(x * b0, OW);
    yp = wrapw(-a1 * ry, PW);
    return wrapw(yz + (yp >>> G), OW);
  endfunction

  // Reference model: transaction bookkeeping at cycle granularity.
  longint ry_m [NCH];
  longint b0_m, a1_m;
  int     last_m;
  bit     busy;
  int     age;
  int     m_ch;
  longint m_x, m_b0s, m_a1s, m_ry, m_y;
  logic [NCH-1:0] acc_mask;
  logic [NCH-1:0] exp_rdy;
  bit     exp_ov;
  int     mc;
  logic signed [BITS_IN-1:0] xs;

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) ry_m[k] = 0;
    b0_m   = 785;
    a1_m   = -1366;
    last_m = NCH - 1;
    busy   = 0;
    age    = 0;
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      model_reset();
      acc_mask = '0;
    end else begin
      exp_rdy = '0;
      exp_ov  = 0;
      if (!busy) begin
        for (int i = 1; i <= NCH; i++) begin
          mc = (last_m + i) % NCH;
          if (exp_rdy == '0 && bus.in_valid[mc]) begin
            exp_rdy[mc] = 1'b1;
            busy  = 1;
            age   = 0;
            m_ch  = mc;
            xs    = bus.in_data[mc*BITS_IN +: BITS_IN];
            m_x   = longint'(xs);
            m_b0s = b0_m;
            m_a1s = a1_m;
          end
        end
      end else begin
        age++;
        if (age == 1) m_ry = ry_m[m_ch];
        if (age == 2) m_y = model_y(m_b0s, m_a1s, m_x, m_ry);
        if (age == 3) begin
          exp_ov = 1;
          chk("mon_out_ch", longint'(bus.out_ch), longint'(m_ch));
          chk("mon_out_data", longint'(bus.out_data), m_y);
          ry_m[m_ch] = m_y;
          last_m     = m_ch;
          busy       = 0;
        end
      end
      chk("mon_in_ready", longint'(bus.in_ready), longint'(exp_rdy));
      chk("mon_out_valid", longint'(bus.out_valid), longint'(exp_ov));
      acc_mask = bus.in_ready;
      if (bus.cfg_we) begin
        b0_m = longint'(bus.cfg_b0);
        a1_m = longint'(bus.cfg_a1);
      end
      if (bus.clear_state) for (int k = 0; k < NCH; k++) ry_m[k] = 0;
    end
  end

  function automatic logic [BITS_IN-1:0] rnd_x();
    longint t;
    if ($urandom_range(0, 1) == 1) t = longint'($urandom_range(0, 4000)) - 2000;
    else t = {$urandom(), $urandom()};
    return t[BITS_IN-1:0];
  endfunction

  // evt: 0 none, 1 cfg write, 2 clear_state; applied in cycle accept+evt_k.
  task automatic send(input int ch, input longint x, input int evt, input int evt_k,
                      output longint y);
    bit acc, got;
    int lat, och;
    acc = 0; got = 0; lat = 0; och = -1; y = 0;
    @(posedge clock); #1;
    bus.in_data[ch*BITS_IN +: BITS_IN] = x[BITS_IN-1:0];
    bus.in_valid[ch] = 1'b1;
    for (int t = 0; t < 10 && !acc; t++) begin
      @(negedge clock);
      if (bus.in_ready[ch]) acc = 1;
    end
    chk("send_accept", longint'(acc), 1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock); #1;
      if (k == 1) bus.in_valid[ch] = 1'b0;
      bus.cfg_we      = (evt == 1 && k == evt_k);
      bus.clear_state = (evt == 2 && k == evt_k);
      @(negedge clock);
      if (bus.out_valid && !got && acc) begin
        got = 1;
        lat = k;
        y   = longint'(bus.out_data);
        och = int'(bus.out_ch);
      end
    end
    if (acc) begin
      chk("send_out", longint'(got), 1);
      chk("send_latency", lat, 3);
      chk("send_out_ch", och, ch);
    end
  endtask

  task automatic pulse_clear();
    @(posedge clock); #1 bus.clear_state = 1'b1;
    @(posedge clock); #1 bus.clear_state = 1'b0;
  endtask

  task automatic write_cfg(input int b0, input int a1);
    @(posedge clock); #1;
    bus.cfg_b0 = COEF_W'(b0);
    bus.cfg_a1 = COEF_W'(a1);
    bus.cfg_we = 1'b1;
    @(posedge clock); #1 bus.cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  longint y;
  int     gch [8];
  int     gcyc[8];
  int     och [8];
  longint od  [8];
  int     ng, no;
  bit     ov_seen, acc2;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.in_valid    = '0;
    bus.in_data     = '0;
    bus.cfg_we      = 1'b0;
    bus.cfg_b0      = '0;
    bus.cfg_a1      = '0;
    bus.clear_state = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", longint'(bus.in_ready), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_ch", longint'(bus.out_ch), 0);
    chk("rst_out_data", longint'(bus.out_data), 0);
    reset_n = 1'b1;

    send(0, 1000, 0, 0, y);  chk("ch0_first", y, 785000);
    send(0, 1000, 0, 0, y);  chk("ch0_second", y, 1832177);
    send(1, -1, 0, 0, y);    chk("ch1_neg", y, -785);
    send(1, 0, 0, 0, y);     chk("ch1_fb_only", y, model_y(785, -1366, 0, -785));

    do_reset();
    @(posedge clock); #1;
    for (int c = 0; c < NCH; c++) bus.in_data[c*BITS_IN +: BITS_IN] = BITS_IN'(1000);
    bus.in_valid = '1;
    ng = 0; no = 0;
    for (int t = 0; t < 60 && no < 8; t++) begin
      @(negedge clock);
      for (int c = 0; c < NCH; c++)
        if (bus.in_ready[c] && ng < 8) begin gch[ng] = c; gcyc[ng] = t; ng++; end
      if (bus.out_valid) begin och[no] = int'(bus.out_ch); od[no] = longint'(bus.out_data); no++; end
    end
    @(posedge clock); #1 bus.in_valid = '0;
    chk("rr_outputs", no, 8);
    for (int i = 0; i < 8; i++) begin
      if (i < ng) chk("rr_grant", gch[i], i % NCH);
      if (i > 0 && i < ng) chk("rr_spacing", gcyc[i] - gcyc[i-1], 4);
      if (i < no) begin
        chk("rr_out_ch", och[i], i % NCH);
        chk("rr_out_data", od[i], (i < NCH) ? 785000 : 1832177);
      end
    end

    pulse_clear();
    send(0, 1000, 0, 0, y);  chk("clr_idle_pre", y, 785000);
    pulse_clear();
    send(0, 1000, 0, 0, y);  chk("clr_idle", y, 785000);

    pulse_clear();
    bus.cfg_b0 = COEF_W'(100);
    bus.cfg_a1 = '0;
    send(0, 1000, 1, 2, y);  chk("cfg_inflight", y, 785000);
    send(0, 1000, 0, 0, y);  chk("cfg_applied", y, 100000);

    write_cfg(785, -1366);
    pulse_clear();
    send(0, 1000, 2, 3, y);  chk("clr_emit_out", y, 785000);
    send(0, 1000, 0, 0, y);  chk("clr_emit_ry", y, 785000);

    write_cfg(100, 0);
    @(posedge clock); #1;
    bus.in_data[2*BITS_IN +: BITS_IN] = BITS_IN'(1000);
    bus.in_valid[2] = 1'b1;
    acc2 = 0;
    for (int t = 0; t < 10 && !acc2; t++) begin
      @(negedge clock);
      if (bus.in_ready[2]) acc2 = 1;
    end
    chk("rst_mid_accept", longint'(acc2), 1);
    @(posedge clock); #1 bus.in_valid[2] = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", longint'(bus.in_ready), 0);
    chk("rst_mid_out_valid", longint'(bus.out_valid), 0);
    chk("rst_mid_out_ch", longint'(bus.out_ch), 0);
    chk("rst_mid_out_data", longint'(bus.out_data), 0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    ov_seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus.out_valid) ov_seen = 1;
    end
    chk("rst_mid_no_out", longint'(ov_seen), 0);
    send(2, 1000, 0, 0, y);  chk("rst_mid_ch2_first", y, 785000);
    send(2, 1000, 0, 0, y);  chk("rst_mid_ch2_second", y, 1832177);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clock); #1;
      for (int c = 0; c < NCH; c++) begin
        if (acc_mask[c]) begin
          bus.in_valid[c] = ($urandom_range(0, 1) == 1);
          bus.in_data[c*BITS_IN +: BITS_IN] = rnd_x();
        end else if (!bus.in_valid[c]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.in_valid[c] = 1'b1;
            bus.in_data[c*BITS_IN +: BITS_IN] = rnd_x();
          end
        end else if ($urandom_range(0, 15) == 0) begin
          bus.in_valid[c] = 1'b0;
        end
      end
      bus.cfg_we      = ($urandom_range(0, 19) == 0);
      bus.cfg_b0      = COEF_W'($urandom());
      bus.cfg_a1      = COEF_W'($urandom());
      bus.clear_state = ($urandom_range(0, 29) == 0);
    end
    @(posedge clock); #1;
    bus.in_valid    = '0;
    bus.cfg_we      = 1'b0;
    bus.clear_state = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock);
    chk("drain_idle", longint'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
